pc_seq: RTL

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// Program-counter sequencer: one NEXT/JMP/CALL/RET step per three cycles,
// with a four-entry return stack and a sticky stack-error flag.
module pc_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_valid,
  output logic       step_ready,
  input  logic [7:0] op,
  input  logic [7:0] paraA,
  input  logic [7:0] paraB,
  input  logic [7:0] target,
  input  logic       flush,
  output logic [7:0] pc,
  output logic       taken,
  output logic       done,
  output logic [2:0] depth,
  output logic       stack_err
);

  localparam int unsigned PC_W     = 8;
  localparam int unsigned DEPTH_W  = 3;
  localparam int unsigned STACK_N  = 4;
  localparam int unsigned PTR_W    = 2;

  localparam logic [3:0] K_JMP  = 4'd1;
  localparam logic [3:0] K_CALL = 4'd2;
  localparam logic [3:0] K_RET  = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_op;
  logic [PC_W-1:0]     r_a;
  logic [PC_W-1:0]     r_b;
  logic [PC_W-1:0]     r_tgt;
  logic [PC_W-1:0]     r_pc;
  logic                r_taken;
  logic                r_done;
  logic [DEPTH_W-1:0]  r_depth;
  logic                r_err;
  logic [PC_W-1:0]     r_stack [STACK_N];

  logic                w_accept;
  logic                w_commit;
  logic                w_cond;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic                w_taken_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_err_set;
  logic [PTR_W-1:0]    w_push_idx;
  logic [PTR_W-1:0]    w_pop_idx;

  assign step_ready = (r_state == S_IDLE) && !flush;
  assign w_accept   = step_valid && step_ready;
  assign w_commit   = (r_state == S_EVAL) && !flush;

  assign pc        = r_pc;
  assign taken     = r_taken;
  assign done      = r_done;
  assign depth     = r_depth;
  assign stack_err = r_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; flush aborts any in-flight step back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EVAL;
      S_EVAL:  w_state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Unsigned condition decode from the latched operands
  always_comb begin
    w_cond = 1'b0;
    case (r_op[3:0])
      4'd0:    w_cond = (r_a == r_b);
      4'd1:    w_cond = (r_a != r_b);
      4'd2:    w_cond = (r_a <  r_b);
      4'd3:    w_cond = (r_a <= r_b);
      4'd4:    w_cond = (r_a >  r_b);
      4'd5:    w_cond = (r_a >= r_b);
      4'd7:    w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_inc   = PC_W'(r_pc + PC_W'(1));
  assign w_push_idx = PTR_W'(r_depth);
  assign w_pop_idx  = PTR_W'(r_depth - DEPTH_W'(1));

  // Commit values; anything not redirecting falls through to pc+1
  always_comb begin
    w_pc_nxt    = w_pc_inc;
    w_taken_nxt = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_op[7:4])
      K_JMP: begin
        if (w_cond) begin
          w_pc_nxt    = r_tgt;
          w_taken_nxt = 1'b1;
        end
      end
      K_CALL: begin
        if (w_cond) begin
          if (r_depth < DEPTH_W'(STACK_N)) begin
            w_push      = 1'b1;
            w_pc_nxt    = r_tgt;
            w_taken_nxt = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      K_RET: begin
        if (w_cond) begin
          if (r_depth != DEPTH_W'(0)) begin
            w_pop       = 1'b1;
            w_pc_nxt    = r_stack[w_pop_idx];
            w_taken_nxt = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Operand capture on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_tgt <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_a   <= paraA;
      r_b   <= paraB;
      r_tgt <= target;
    end
  end

  // Architectural state updates on the EVAL->DONE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_done  <= 1'b0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        r_pc    <= w_pc_nxt;
        r_taken <= w_taken_nxt;
        if (w_push)    r_depth <= DEPTH_W'(r_depth + DEPTH_W'(1));
        if (w_pop)     r_depth <= DEPTH_W'(r_depth - DEPTH_W'(1));
        if (w_err_set) r_err   <= 1'b1;
      end
    end
  end

  // Stack storage needs no reset: depth gates every read
  always_ff @(posedge clk) begin
    if (w_commit && w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

endmodule
